// File: rtl/corelet_feeder.sv
// Issuing-side sequencer for the corelet input path: fills L0 from SRAM with the
// kernel, loads it into the MAC array, then fills and streams the activations.
module corelet_feeder #(
  parameter int row      = 8,
  parameter int col      = 8,
  parameter int bw       = 4,
  parameter int addr_w   = 11,
  parameter int l0_depth = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [addr_w-1:0]   w_base,
  input  logic [addr_w-1:0]   a_base,
  input  logic [6:0]          num_act,
  output logic                sram_cen,
  output logic                sram_wen,
  output logic [addr_w-1:0]   sram_addr,
  input  logic [row*bw-1:0]   sram_dout,
  output logic [row*bw-1:0]   l0_in,
  output logic                l0_wr,
  input  logic                l0_full,
  output logic                l0_rd,
  output logic                load,
  output logic                execute,
  output logic                busy,
  output logic                done
);

  typedef enum logic [3:0] {
    IDLE, WFILL, WSET, WLOAD, WGAP, AFILL, ASET, EXEC, DRAIN, DONE
  } state_t;

  localparam logic [7:0] COL_N  = 8'(col);
  localparam logic [7:0] GAP_N  = 8'(row + col);
  localparam logic [7:0] SET_N  = 8'd2;
  localparam logic [6:0] DEPTH  = 7'(l0_depth);

  state_t            state, state_n;
  logic [7:0]        cnt, cnt_n;
  logic [addr_w-1:0] a_base_r, a_base_n;
  logic [6:0]        n_r, n_n;
  logic [addr_w-1:0] addr_n, addr_next;
  logic              cen_n, wr_n, rd_n, load_n, exec_n, done_n;
  logic [7:0]        fill_len;

  // SRAM data lands one cycle after issue, lining up with L0's delayed write.
  assign l0_in    = sram_dout;
  assign sram_wen = 1'b1;

  // Address advances only past a word that was actually issued; stalls hold it.
  assign addr_next = sram_cen ? sram_addr : sram_addr + 1'b1;
  assign fill_len  = (state == WFILL) ? COL_N : {1'b0, n_r};

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    a_base_n = a_base_r;
    n_n      = n_r;
    addr_n   = sram_addr;
    cen_n    = 1'b1;
    wr_n     = 1'b0;
    rd_n     = 1'b0;
    load_n   = 1'b0;
    exec_n   = 1'b0;
    done_n   = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_n  = WFILL;
        a_base_n = a_base;
        n_n      = (num_act > DEPTH) ? DEPTH : num_act;
        addr_n   = w_base;
        cen_n    = l0_full;
        wr_n     = !l0_full;
        cnt_n    = l0_full ? 8'd0 : 8'd1;
      end
      WFILL, AFILL: begin
        if (cnt == fill_len) begin
          state_n = (state == WFILL) ? WSET : ASET;
          cnt_n   = 8'd1;
        end else begin
          addr_n = addr_next;
          if (!l0_full) begin
            cen_n = 1'b0;
            wr_n  = 1'b1;
            cnt_n = cnt + 8'd1;
          end
        end
      end
      WSET, ASET: begin
        if (cnt == SET_N) begin
          state_n = (state == WSET) ? WLOAD : EXEC;
          cnt_n   = 8'd1;
          rd_n    = 1'b1;
          load_n  = (state == WSET);
          exec_n  = (state == ASET);
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      WLOAD: begin
        if (cnt == COL_N) begin
          state_n = WGAP;
          cnt_n   = 8'd1;
        end else begin
          cnt_n  = cnt + 8'd1;
          rd_n   = 1'b1;
          load_n = 1'b1;
        end
      end
      WGAP: begin
        if (cnt != GAP_N) begin
          cnt_n = cnt + 8'd1;
        end else if (n_r == 7'd0) begin
          state_n = DONE;
          cnt_n   = 8'd0;
          done_n  = 1'b1;
        end else begin
          state_n = AFILL;
          addr_n  = a_base_r;
          cen_n   = l0_full;
          wr_n    = !l0_full;
          cnt_n   = l0_full ? 8'd0 : 8'd1;
        end
      end
      EXEC: begin
        if (cnt == {1'b0, n_r}) begin
          state_n = DRAIN;
          cnt_n   = 8'd1;
        end else begin
          cnt_n  = cnt + 8'd1;
          rd_n   = 1'b1;
          exec_n = 1'b1;
        end
      end
      DRAIN: begin
        if (cnt == GAP_N) begin
          state_n = DONE;
          cnt_n   = 8'd0;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      DONE: begin
        state_n = IDLE;
        cnt_n   = 8'd0;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 8'd0;
      end
    endcase
  end

  // Outputs are registered from next-state decode so they match the new state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      a_base_r  <= '0;
      n_r       <= 7'd0;
      sram_cen  <= 1'b1;
      sram_addr <= '0;
      l0_wr     <= 1'b0;
      l0_rd     <= 1'b0;
      load      <= 1'b0;
      execute   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      a_base_r  <= a_base_n;
      n_r       <= n_n;
      sram_cen  <= cen_n;
      sram_addr <= addr_n;
      l0_wr     <= wr_n;
      l0_rd     <= rd_n;
      load      <= load_n;
      execute   <= exec_n;
      busy      <= (state_n != IDLE);
      done      <= done_n;
    end
  end

endmodule
